fs_prime: RTL and testbench



---
 rtl/fs_prime_pkg.sv | 31 +++
 rtl/fs_prime_addr_gen.sv | 46 ++++
 rtl/fs_prime.sv | 126 ++++++++++++
 tb/tb_fs_prime.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fs_prime_pkg.sv
// Shared milestone-2 definitions for the fetch-S' block: FSM states, segment offsets, limits.
package fs_prime_pkg;

    typedef enum logic [1:0] {
        S_FS_IDLE,
        S_FS_ISSUE,
        S_FS_DRAIN,
        S_FS_DONE
    } FS_state_type;

    localparam int unsigned SP_Y_OFS  = 0;
    localparam int unsigned SP_U_OFS  = 76800;
    localparam int unsigned SP_V_OFS  = 115200;
    localparam int unsigned STRIDE_Y  = 320;
    localparam int unsigned STRIDE_UV = 160;
    localparam int unsigned RB_MAX    = 29;
    localparam int unsigned CB_MAX_Y  = 39;
    localparam int unsigned CB_MAX_UV = 19;

    localparam logic [1:0] PLANE_Y = 2'd0;
    localparam logic [1:0] PLANE_U = 2'd1;
    localparam logic [1:0] PLANE_V = 2'd2;

    function automatic logic fs_legal(input logic [1:0] plane, input logic [4:0] rb,
                                      input logic [5:0] cb);
        logic [5:0] cb_max;
        cb_max = (plane == PLANE_Y) ? 6'(CB_MAX_Y) : 6'(CB_MAX_UV);
        return (plane != 2'd3) && (rb <= 5'(RB_MAX)) && (cb <= cb_max);
    endfunction

endpackage

// File: rtl/fs_prime_addr_gen.sv
// Combinational S' SRAM address generator: base + (RB*8+r)*stride + CB*8+c, shift-add only.
module fs_prime_addr_gen
    import fs_prime_pkg::*;
#(
    parameter int unsigned SP_BASE = 76800
) (
    input  logic [1:0]  plane,
    input  logic [4:0]  rb,
    input  logic [5:0]  cb,
    input  logic [2:0]  r,
    input  logic [2:0]  c,
    output logic [17:0] addr
);

    localparam logic [17:0] BASE_Y = 18'(SP_BASE + SP_Y_OFS);
    localparam logic [17:0] BASE_U = 18'(SP_BASE + SP_U_OFS);
    localparam logic [17:0] BASE_V = 18'(SP_BASE + SP_V_OFS);

    logic [7:0]  row;
    logic [8:0]  col;
    logic [17:0] row_w;
    logic [17:0] base;
    logic [17:0] row_ofs;

    always_comb begin
        // RB*8+r and CB*8+c are plain concatenations since r, c are 3 bits
        row     = {rb, r};
        col     = {cb, c};
        row_w   = {10'd0, row};
        base    = BASE_Y;
        row_ofs = (row_w << 8) + (row_w << 6);
        case (plane)
            PLANE_U: begin
                base    = BASE_U;
                row_ofs = (row_w << 7) + (row_w << 5);
            end
            PLANE_V: begin
                base    = BASE_V;
                row_ofs = (row_w << 7) + (row_w << 5);
            end
            default: ;
        endcase
        addr = base + row_ofs + {9'd0, col};
    end

endmodule

// File: rtl/fs_prime.sv
// Fetch-S' block: reads one 8x8 S' block from SRAM and writes it sign-extended to DP-RAM port A.
module fs_prime
    import fs_prime_pkg::*;
#(
    parameter int unsigned SRAM_LAT = 2,
    parameter int unsigned SP_BASE  = 76800,
    parameter int unsigned DP_BASE  = 0
) (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    input  logic        FS_start,
    input  logic [1:0]  FS_plane,
    input  logic [4:0]  FS_RB,
    input  logic [5:0]  FS_CB,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic [6:0]  DP_address,
    output logic [31:0] DP_write_data,
    output logic        DP_we,
    output logic        FS_busy,
    output logic        FS_done,
    output logic        FS_err
);

    FS_state_type state_q, state_d;

    logic [1:0]  plane_q;
    logic [4:0]  rb_q;
    logic [5:0]  cb_q;
    logic [5:0]  idx_q;
    logic [SRAM_LAT-1:0] vld_q;
    logic [5:0]  idx_pipe_q [SRAM_LAT];

    logic        idle;
    logic        issuing;
    logic        start_ok;
    logic        start_bad;
    logic        addr_load;
    logic [1:0]  ag_plane;
    logic [4:0]  ag_rb;
    logic [5:0]  ag_cb;
    logic [5:0]  ag_idx;
    logic [17:0] ag_addr;

    assign idle      = (state_q == S_FS_IDLE);
    assign issuing   = (state_q == S_FS_ISSUE);
    assign start_ok  = idle && FS_start && fs_legal(FS_plane, FS_RB, FS_CB);
    assign start_bad = idle && FS_start && !fs_legal(FS_plane, FS_RB, FS_CB);

    // The address register is preloaded with element 0 at start, then always one index ahead.
    assign ag_plane  = idle ? FS_plane : plane_q;
    assign ag_rb     = idle ? FS_RB : rb_q;
    assign ag_cb     = idle ? FS_CB : cb_q;
    assign ag_idx    = idle ? 6'd0 : idx_q + 6'd1;
    assign addr_load = start_ok || (issuing && idx_q != 6'd63);

    fs_prime_addr_gen #(
        .SP_BASE(SP_BASE)
    ) u_addr_gen (
        .plane(ag_plane),
        .rb   (ag_rb),
        .cb   (ag_cb),
        .r    (ag_idx[5:3]),
        .c    (ag_idx[2:0]),
        .addr (ag_addr)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FS_IDLE:  if (start_ok) state_d = S_FS_ISSUE;
            S_FS_ISSUE: if (idx_q == 6'd63) state_d = S_FS_DRAIN;
            S_FS_DRAIN: if (vld_q == '0) state_d = S_FS_DONE;
            S_FS_DONE:  state_d = S_FS_IDLE;
            default:    state_d = S_FS_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_FS_IDLE;
            plane_q       <= '0;
            rb_q          <= '0;
            cb_q          <= '0;
            idx_q         <= '0;
            vld_q         <= '0;
            for (int i = 0; i < SRAM_LAT; i++) idx_pipe_q[i] <= '0;
            SRAM_address  <= '0;
            DP_address    <= 7'(DP_BASE);
            DP_write_data <= '0;
            DP_we         <= 1'b0;
            FS_err        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (idle && FS_start) begin
                plane_q <= FS_plane;
                rb_q    <= FS_RB;
                cb_q    <= FS_CB;
                idx_q   <= '0;
            end else if (issuing) begin
                idx_q <= idx_q + 6'd1;
            end
            if (addr_load) SRAM_address <= ag_addr;
            FS_err <= start_bad;

            vld_q[0]      <= issuing;
            idx_pipe_q[0] <= idx_q;
            for (int i = 1; i < SRAM_LAT; i++) begin
                vld_q[i]      <= vld_q[i-1];
                idx_pipe_q[i] <= idx_pipe_q[i-1];
            end

            DP_we <= vld_q[SRAM_LAT-1];
            if (vld_q[SRAM_LAT-1]) begin
                DP_address    <= 7'(DP_BASE) + {1'b0, idx_pipe_q[SRAM_LAT-1]};
                DP_write_data <= {{16{SRAM_read_data[15]}}, SRAM_read_data};
            end
        end
    end

    assign SRAM_we_n = 1'b1;
    assign FS_busy   = (state_q == S_FS_ISSUE) || (state_q == S_FS_DRAIN);
    assign FS_done   = (state_q == S_FS_DONE);

endmodule

// File: tb/tb_fs_prime.sv
// Self-checking bench for fs_prime: SRAM latency model, write scoreboard, directed scenarios.
module tb_fs_prime;

    localparam int unsigned LAT = 2;

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } exp_t;

    logic        clk;
    logic        Reset;
    logic        FS_start;
    logic [1:0]  FS_plane;
    logic [4:0]  FS_RB;
    logic [5:0]  FS_CB;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic [6:0]  DP_address;
    logic [31:0] DP_write_data;
    logic        DP_we;
    logic        FS_busy;
    logic        FS_done;
    logic        FS_err;

    int          n_asserts = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          err_cnt = 0;
    int          first_wr = -1;
    exp_t        sbq[$];
    logic [31:0] dp_mem [64];
    logic [17:0] iss [64];
    logic [17:0] a_d [LAT];

    fs_prime #(
        .SRAM_LAT(LAT),
        .SP_BASE (76800),
        .DP_BASE (0)
    ) dut (
        .CLOCK_50_I    (clk),
        .Reset         (Reset),
        .FS_start      (FS_start),
        .FS_plane      (FS_plane),
        .FS_RB         (FS_RB),
        .FS_CB         (FS_CB),
        .SRAM_address  (SRAM_address),
        .SRAM_we_n     (SRAM_we_n),
        .SRAM_read_data(SRAM_read_data),
        .DP_address    (DP_address),
        .DP_write_data (DP_write_data),
        .DP_we         (DP_we),
        .FS_busy       (FS_busy),
        .FS_done       (FS_done),
        .FS_err        (FS_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] sram_fn(input logic [17:0] a);
        if (a == 18'd76800) return 16'h8001;
        if (a == 18'd79047) return 16'h7FFF;
        return 16'(a * 18'd37) ^ a[17:2];
    endfunction

    function automatic logic [17:0] model_addr(input int pl, input int rb, input int cb,
                                               input int r, input int c);
        int base;
        int stride;
        base   = 76800 + ((pl == 0) ? 0 : (pl == 1) ? 76800 : 115200);
        stride = (pl == 0) ? 320 : 160;
        return 18'(base + (rb * 8 + r) * stride + cb * 8 + c);
    endfunction

    // SRAM: data for the address seen in cycle t appears in cycle t+LAT
    always @(posedge clk) begin
        a_d[0] <= SRAM_address;
        for (int i = 1; i < LAT; i++) a_d[i] <= a_d[i-1];
    end
    assign SRAM_read_data = sram_fn(a_d[LAT-1]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (DP_we === 1'b1) begin
            exp_t e;
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            dp_mem[DP_address] = DP_write_data;
            if (sbq.size() == 0) begin
                chk("dp_we_unexpected", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("dp_address", 32'(DP_address), 32'(e.a));
                chk("dp_write_data", DP_write_data, e.d);
            end
        end
        if (FS_err === 1'b1) err_cnt++;
    end

    task automatic chk_reset_vals();
        chk("rst_sram_address", 32'(SRAM_address), 32'd0);
        chk("rst_sram_we_n", 32'(SRAM_we_n), 32'd1);
        chk("rst_dp_address", 32'(DP_address), 32'd0);
        chk("rst_dp_write_data", DP_write_data, 32'd0);
        chk("rst_dp_we", 32'(DP_we), 32'd0);
        chk("rst_busy", 32'(FS_busy), 32'd0);
        chk("rst_done", 32'(FS_done), 32'd0);
        chk("rst_err", 32'(FS_err), 32'd0);
    endtask

    task automatic run_block(input int pl, input int rb, input int cb,
                             input int inject_at, input int abort_at);
        int          s;
        int          w0;
        int          e0;
        bit          done;
        logic [17:0] ea [64];
        logic [15:0] d;
        @(posedge clk);
        #1;
        FS_start = 1'b1;
        FS_plane = 2'(pl);
        FS_RB    = 5'(rb);
        FS_CB    = 6'(cb);
        s        = cyc;
        w0       = wr_cnt;
        e0       = err_cnt;
        first_wr = -1;
        for (int i = 0; i < 64; i++) begin
            ea[i] = model_addr(pl, rb, cb, i / 8, i % 8);
            d     = sram_fn(ea[i]);
            sbq.push_back({7'(i), {{16{d[15]}}, d}});
        end
        @(posedge clk);
        #1;
        FS_start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == inject_at + 1) FS_start = 1'b0;
            iss[k] = SRAM_address;
            chk("sram_address", 32'(SRAM_address), 32'(ea[k]));
            chk("sram_we_n", 32'(SRAM_we_n), 32'd1);
            if (k == 0) chk("busy_on", 32'(FS_busy), 32'd1);
            if (k == inject_at) begin
                FS_start = 1'b1;
                FS_plane = 2'd3;
                FS_RB    = 5'd31;
            end
            if (k == abort_at) begin
                Reset = 1'b1;
                #1;
                chk_reset_vals();
                sbq.delete();
                @(negedge clk);
                @(negedge clk);
                chk_reset_vals();
                Reset = 1'b0;
                return;
            end
        end
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (FS_done === 1'b1) done = 1'b1;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("done_latency", 32'(cyc - s), 32'(64 + LAT + 2));
        chk("write_count", 32'(wr_cnt - w0), 32'd64);
        chk("first_write_latency", 32'(first_wr - s), 32'(LAT + 2));
        chk("no_err_pulse", 32'(err_cnt - e0), 32'd0);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        @(negedge clk);
        chk("busy_off", 32'(FS_busy), 32'd0);
        chk("addr_hold", 32'(SRAM_address), 32'(ea[63]));
    endtask

    task automatic bad_start(input int pl, input int rb, input int cb,
                             input logic [17:0] last_addr);
        int w0;
        int e0;
        @(posedge clk);
        #1;
        FS_start = 1'b1;
        FS_plane = 2'(pl);
        FS_RB    = 5'(rb);
        FS_CB    = 6'(cb);
        w0       = wr_cnt;
        e0       = err_cnt;
        @(posedge clk);
        #1;
        FS_start = 1'b0;
        @(negedge clk);
        chk("err_pulse", 32'(FS_err), 32'd1);
        chk("err_not_busy", 32'(FS_busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("err_single", 32'(err_cnt - e0), 32'd1);
        chk("err_no_writes", 32'(wr_cnt - w0), 32'd0);
        chk("err_no_reads", 32'(SRAM_address), 32'(last_addr));
        chk("err_idle", 32'(FS_busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset    = 1'b1;
        FS_start = 1'b0;
        FS_plane = 2'd0;
        FS_RB    = 5'd0;
        FS_CB    = 6'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        Reset = 1'b0;

        run_block(0, 0, 0, -1, -1);
        chk("y00_first", 32'(iss[0]), 32'd76800);
        chk("y00_c7", 32'(iss[7]), 32'd76807);
        chk("y00_r1", 32'(iss[8]), 32'd77120);
        chk("dp0_neg", dp_mem[0], 32'hFFFF8001);
        chk("dp63_pos", dp_mem[63], 32'h00007FFF);

        run_block(0, 29, 39, -1, -1);
        chk("y_max_first", 32'(iss[0]), 32'd151352);
        chk("y_max_last", 32'(iss[63]), 32'd153599);

        run_block(1, 1, 2, -1, -1);
        chk("u_first", 32'(iss[0]), 32'd154896);

        run_block(2, 0, 19, -1, -1);
        chk("v_last", 32'(iss[63]), 32'd193279);

        bad_start(3, 0, 0, 18'd193279);
        bad_start(1, 0, 20, 18'd193279);
        bad_start(0, 30, 0, 18'd193279);

        run_block(0, 3, 5, 10, -1);
        run_block(1, 4, 4, -1, 20);
        run_block(2, 10, 7, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
